// File: rtl/dot_prod_pkg.sv
// Shared types, default widths and accumulate helper for the dot-product MAC.
package dot_prod_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Two's-complement add overflow: operands share a sign that the sum does not.
  function automatic logic add_overflow(input logic a_sign,
                                        input logic b_sign,
                                        input logic sum_sign);
    return (a_sign == b_sign) && (sum_sign != a_sign);
  endfunction

endpackage

// File: rtl/dot_prod_mac_if.sv
// Control, element stream and result port bundle of the dot-product MAC.
interface dot_prod_mac_if
  import dot_prod_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
);
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     busy;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     overflow;

  modport master (
    output start, len, in_valid, in_a, in_b, out_ready,
    input  busy, in_ready, out_valid, out_data, overflow
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready,
    output busy, in_ready, out_valid, out_data, overflow
  );
endinterface

// File: rtl/regn.sv
// Generic N-bit holding register with synchronous clear and load enable.
module regn #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Clear wins over load; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dot_prod_mac.sv
// Streaming signed multiply-accumulate: sums len products of (a[i], b[i]).
module dot_prod_mac
  import dot_prod_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  dot_prod_mac_if.slave bus
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_acc_w_check
    $error("dot_prod_mac: ACC_W must be at least 2*DATA_W");
  end

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         cnt_inc;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     prod_valid_q, prod_valid_d;
  logic                     overflow_q, overflow_d;
  logic                     busy_q, busy_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic                     start_acc;
  logic                     in_acc;
  logic signed [PROD_W-1:0] a_ext, b_ext, prod_mul;
  logic [ACC_W-1:0]         prod_sext;
  logic [ACC_W-1:0]         acc_q, acc_sum;
  logic                     sum_ovf;

  // Multiply operands, sign-extended product and accumulate with overflow flag.
  always_comb begin
    a_ext     = PROD_W'(bus.in_a);
    b_ext     = PROD_W'(bus.in_b);
    prod_mul  = a_ext * b_ext;
    prod_sext = ACC_W'(prod_q);
    acc_sum   = acc_q + prod_sext;
    sum_ovf   = add_overflow(acc_q[ACC_W-1], prod_sext[ACC_W-1], acc_sum[ACC_W-1]);
  end

  // Next-state, datapath control and registered-output decode.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    prod_d       = prod_q;
    prod_valid_d = 1'b0;
    overflow_d   = overflow_q;
    start_acc    = 1'b0;
    in_acc       = 1'b0;
    cnt_inc      = cnt_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          len_d     = bus.len;
          cnt_d     = '0;
          state_d   = (bus.len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.in_valid && in_ready_q) begin
          in_acc = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Product stage: capture on accept, flag valid for exactly one cycle.
    if (in_acc) begin
      prod_d       = prod_mul;
      prod_valid_d = 1'b1;
    end

    // Sticky overflow, cleared when a new dot product starts.
    if (start_acc) begin
      overflow_d = 1'b0;
    end else if (prod_valid_q && sum_ovf) begin
      overflow_d = 1'b1;
    end

    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == RUN);
    // Result is offered from the second DONE cycle until the handshake.
    out_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  // State, counter, product stage and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  regn #(
    .N (ACC_W)
  ) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (prod_valid_q),
    .d   (acc_sum),
    .q   (acc_q)
  );

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_dot_prod_mac.sv
// Directed and randomized bench for dot_prod_mac against an arithmetic model.
module tb_dot_prod_mac;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (AW - 1));

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic signed [DW-1:0] va [16];
  logic signed [DW-1:0] vb [16];

  dot_prod_mac_if #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) bus ();

  dot_prod_mac #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Exact integer sum of products, wrapped to AW bits after each step.
  task automatic model(input int n, output longint acc, output bit ovf);
    longint s;
    logic [AW-1:0] t;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = acc + longint'(va[i]) * longint'(vb[i]);
      if (s > MAXV || s < MINV) ovf = 1'b1;
      t   = AW'(s);
      acc = longint'($signed(t));
    end
  endtask

  // gap_mode: 0 always valid, 1 alternating, 2 random.
  task automatic run_vec(input int n, input int gap_mode, input int hold, input int bogus_at);
    longint        exp_acc;
    bit            exp_ovf;
    int            idx;
    int            cyc;
    bit            acc_now;
    logic [AW-1:0] exp_bits;
    logic [AW-1:0] obs_d;

    model(n, exp_acc, exp_ovf);
    exp_bits      = AW'(exp_acc);
    bus.out_ready = (hold == 0);
    bus.start     = 1'b1;
    bus.len       = LW'(n);
    tick();
    bus.start = 1'b0;
    chk1("busy_after_start", bus.busy, 1'b1);
    chk1("ovf_cleared_on_start", bus.overflow, 1'b0);

    if (n == 0) begin
      chk1("len0_valid_lag", bus.out_valid, 1'b0);
      chk1("len0_in_ready", bus.in_ready, 1'b0);
      tick();
    end else begin
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 1000) begin
        case (gap_mode)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = ((cyc % 2) == 0);
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        bus.in_a = va[idx];
        bus.in_b = vb[idx];
        if (cyc == bogus_at) begin
          bus.start = 1'b1;
          bus.len   = LW'(9);
        end
        acc_now = bus.in_valid && bus.in_ready;
        tick();
        bus.start = 1'b0;
        if (acc_now) idx++;
        cyc++;
      end
      chkw("accept_count", 64'(idx), 64'(n));
      // Keep offering junk; none of it may be taken.
      bus.in_valid = 1'b1;
      bus.in_a     = DW'(7);
      bus.in_b     = DW'(7);
      chk1("in_ready_drop", bus.in_ready, 1'b0);
      chk1("valid_lat0", bus.out_valid, 1'b0);
      tick();
      chk1("valid_lat1", bus.out_valid, 1'b0);
      chk1("in_ready_drain", bus.in_ready, 1'b0);
      tick();
      bus.in_valid = 1'b0;
    end

    chk1("out_valid", bus.out_valid, 1'b1);
    obs_d = bus.out_data;
    chkw("out_data", 64'(obs_d), 64'(exp_bits));
    chk1("overflow", bus.overflow, exp_ovf);
    chk1("busy_done", bus.busy, 1'b1);

    for (int h = 0; h < hold; h++) begin
      tick();
      obs_d = bus.out_data;
      chk1("hold_valid", bus.out_valid, 1'b1);
      chkw("hold_data", 64'(obs_d), 64'(exp_bits));
      chk1("hold_busy", bus.busy, 1'b1);
    end

    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk1("post_hs_valid", bus.out_valid, 1'b0);
    chk1("post_hs_busy", bus.busy, 1'b0);
    chk1("post_hs_in_ready", bus.in_ready, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] obs_d;
    int            n;
    checks        = 0;
    failures      = 0;
    clk           = 1'b0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset values.
    #12;
    obs_d = bus.out_data;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chkw("rst_out_data", 64'(obs_d), 64'd0);
    chk1("rst_overflow", bus.overflow, 1'b0);
    rst = 1'b0;
    tick();

    // len=4 back-to-back with out_ready high.
    va[0] = 1;  vb[0] = 2;
    va[1] = 3;  vb[1] = 4;
    va[2] = -5; vb[2] = 6;
    va[3] = 7;  vb[3] = -8;
    run_vec(4, 0, 0, -1);

    // len=3 with in_valid toggling 1-0-1-0-1.
    va[0] = 100; vb[0] = 100;
    va[1] = -1;  vb[1] = -1;
    va[2] = 2;   vb[2] = 3;
    run_vec(3, 1, 0, -1);

    // len=0 with result held back for 5 cycles.
    run_vec(0, 0, 5, -1);

    // Accumulator wrap with sticky overflow.
    for (int i = 0; i < 3; i++) begin
      va[i] = -32768;
      vb[i] = -32768;
    end
    run_vec(3, 0, 1, -1);

    // Start pulse during RUN is ignored; len stays 2.
    va[0] = 21;  vb[0] = -4;
    va[1] = 300; vb[1] = 5;
    va[2] = 1000; vb[2] = 1000;
    run_vec(2, 1, 0, 1);

    // Asynchronous reset after 2 of 5 accepts.
    va[0] = 11; vb[0] = 13;
    bus.start = 1'b1;
    bus.len   = LW'(5);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = va[0];
    bus.in_b     = vb[0];
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    obs_d = bus.out_data;
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_in_ready", bus.in_ready, 1'b0);
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chkw("midrst_out_data", 64'(obs_d), 64'd0);
    chk1("midrst_overflow", bus.overflow, 1'b0);
    #2 rst = 1'b0;
    tick();
    va[0] = 3; vb[0] = 3;
    run_vec(1, 0, 0, -1);

    // Randomized vectors, gaps and back-pressure.
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        va[i] = DW'($urandom);
        vb[i] = DW'($urandom);
      end
      run_vec(n, 2, int'($urandom_range(0, 3)), (t == 3) ? 0 : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
